// File: rtl/seg_display_ctrl_if.sv
// Input handshake for the BCD display controller.
// A value transfers on a rising edge where in_valid && in_ready; valid is not queued when ready is low.
interface seg_display_ctrl_if #(
   parameter int BIN_W = 14
);
   logic             in_valid;
   logic             in_ready;
   logic [BIN_W-1:0] in_value;

   modport master (output in_valid, output in_value, input in_ready);
   modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/seg_display_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) driving the
// 7-segment digit nibbles, with clamp-to-9s on overflow and leading-zero blanking.
module seg_display_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_W      = 14,
   parameter int LZ_BLANK   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seg_display_ctrl_if.slave       bus,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic [NUM_DIGITS-1:0]   digit_on,
   output logic                    overflow,
   output logic                    busy,
   output logic [1:0]              state_dbg
);
   localparam int ACC_W = 4 * NUM_DIGITS;
   localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);
   localparam logic [39:0] MAX_VAL = 40'(10 ** NUM_DIGITS) - 40'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [BIN_W-1:0] shreg;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             clamp;

   logic [ACC_W-1:0]      adj;
   logic [ACC_W-1:0]      load_val;
   logic [NUM_DIGITS-1:0] on_next;
   logic                  any_nz;

   // Add-3 correction applied to every nibble before the shift.
   always_comb begin
      adj = acc;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
   end

   // Digit i stays lit when it or any more significant digit is nonzero.
   always_comb begin
      load_val = clamp ? {NUM_DIGITS{4'h9}} : acc;
      on_next  = '0;
      any_nz   = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         any_nz     = any_nz | (|load_val[4*i +: 4]);
         on_next[i] = (LZ_BLANK == 0) || (i == 0) || any_nz;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shreg    <= '0;
         acc      <= '0;
         cnt      <= '0;
         clamp    <= 1'b0;
         bcd      <= '0;
         digit_on <= NUM_DIGITS'(1);
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg <= bus.in_value;
                  acc   <= '0;
                  cnt   <= '0;
                  clamp <= (40'(bus.in_value) > MAX_VAL);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc   <= {adj[ACC_W-2:0], shreg[BIN_W-1]};
               shreg <= shreg << 1;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(BIN_W - 1)) state <= DONE;
            end
            DONE: begin
               bcd      <= load_val;
               digit_on <= on_next;
               overflow <= clamp;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready = (state == IDLE);
   assign busy         = (state != IDLE);
   assign state_dbg    = state;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: decimal-arithmetic reference model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_seg_display_ctrl;
   localparam int BIN_W = 14;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   seg_display_ctrl_if #(.BIN_W(BIN_W)) bus ();
   seg_display_ctrl_if #(.BIN_W(BIN_W)) bus0 ();

   logic [15:0] bcd, bcd0;
   logic [3:0]  digit_on, digit_on0;
   logic        overflow, overflow0, busy, busy0;
   logic [1:0]  state_dbg, state_dbg0;

   assign bus0.in_valid = bus.in_valid;
   assign bus0.in_value = bus.in_value;

   seg_display_ctrl #(.NUM_DIGITS(4), .BIN_W(BIN_W), .LZ_BLANK(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .bcd(bcd), .digit_on(digit_on),
      .overflow(overflow), .busy(busy), .state_dbg(state_dbg));

   seg_display_ctrl #(.NUM_DIGITS(4), .BIN_W(BIN_W), .LZ_BLANK(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .bcd(bcd0), .digit_on(digit_on0),
      .overflow(overflow0), .busy(busy0), .state_dbg(state_dbg0));

   int n_checks = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: decimal digits by division, clamp above 9999.
   function automatic logic [15:0] exp_bcd_of(input int v);
      logic [15:0] r;
      int p;
      r = '0;
      if (v > 9999) return 16'h9999;
      p = 1;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] exp_on_of(input int v);
      logic [3:0] r;
      int p;
      r = 4'b0001;
      p = 10;
      for (int i = 1; i < 4; i++) begin
         if (v >= p) r[i] = 1'b1;
         p = p * 10;
      end
      return r;
   endfunction

   // Cycle-level timing of the model: accept, then results appear BIN_W+1 edges later.
   int          m_cnt = 0;
   int          m_v = 0;
   logic [15:0] m_bcd = '0;
   logic [3:0]  m_on = 4'b0001;
   logic [3:0]  m_on0 = 4'b0001;
   logic        m_ovf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0;
         m_bcd = '0;
         m_on  = 4'b0001;
         m_on0 = 4'b0001;
         m_ovf = 1'b0;
      end else if (m_cnt == 1) begin
         m_bcd = exp_bcd_of(m_v);
         m_on  = exp_on_of(m_v);
         m_on0 = 4'b1111;
         m_ovf = (m_v > 9999);
         m_cnt = 0;
      end else if (m_cnt > 1) begin
         m_cnt = m_cnt - 1;
      end else if (bus.in_valid) begin
         m_v   = int'(bus.in_value);
         m_cnt = BIN_W + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_bcd", bcd, m_bcd);
         check("cyc_digit_on", digit_on, m_on);
         check("cyc_overflow", overflow, m_ovf);
         check("cyc_in_ready", bus.in_ready, m_cnt == 0);
         check("cyc_busy", busy, m_cnt != 0);
         check("cyc_bcd_lz0", bcd0, m_bcd);
         check("cyc_digit_on_lz0", digit_on0, m_on0);
      end
   end

   task automatic send(input int v);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("send_ready_timeout", bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_value = BIN_W'(v);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("idle_timeout", bus.in_ready, 1'b1);
   endtask

   task automatic convert(input int v);
      send(v);
      wait_idle();
   endtask

   initial begin
      int n;
      bus.in_valid = 1'b0;
      bus.in_value = '0;

      // 1: asynchronous reset mid-clock
      #12 rst_n = 1'b0;
      #1;
      check("rst_bcd", bcd, 16'h0000);
      check("rst_digit_on", digit_on, 4'b0001);
      check("rst_overflow", overflow, 1'b0);
      check("rst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);

      // 2: 1234 and the accept-to-ready latency
      send(1234);
      n = 0;
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("lat_ready_low_cycles", n, 15);
      check("t2_bcd", bcd, 16'h1234);
      check("t2_digit_on", digit_on, 4'b1111);
      check("t2_overflow", overflow, 1'b0);

      // 3: leading-zero blanking
      convert(7);
      check("t3_bcd_7", bcd, 16'h0007);
      check("t3_on_7", digit_on, 4'b0001);
      check("t3_on_7_lz0", digit_on0, 4'b1111);
      convert(0);
      check("t3_bcd_0", bcd, 16'h0000);
      check("t3_on_0", digit_on, 4'b0001);
      check("t3_on_0_lz0", digit_on0, 4'b1111);

      // 4: clamp boundaries
      convert(9999);
      check("t4_bcd_9999", bcd, 16'h9999);
      check("t4_ovf_9999", overflow, 1'b0);
      convert(10000);
      check("t4_bcd_10000", bcd, 16'h9999);
      check("t4_ovf_10000", overflow, 1'b1);
      check("t4_on_10000", digit_on, 4'b1111);
      convert(16383);
      check("t4_bcd_16383", bcd, 16'h9999);
      check("t4_ovf_16383", overflow, 1'b1);

      // 5: ignored pulse while busy, then held valid accepted on the first idle cycle
      send(1234);
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_value = BIN_W'(5555);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_value = BIN_W'(42);
      wait_idle();
      check("t5_bcd_1234", bcd, 16'h1234);
      check("t5_ovf_1234", overflow, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("t5_accepted_42", bus.in_ready, 1'b0);
      wait_idle();
      check("t5_bcd_42", bcd, 16'h0042);
      check("t5_on_42", digit_on, 4'b0011);

      // 6: reset during conversion of 8888
      send(8888);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_bcd", bcd, 16'h0000);
      check("t6_rst_digit_on", digit_on, 4'b0001);
      check("t6_rst_overflow", overflow, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t6_no_8888", bcd, 16'h0000);
      convert(300);
      check("t6_bcd_300", bcd, 16'h0300);
      check("t6_on_300", digit_on, 4'b0111);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
